// File: rtl/ex_div_unit.sv
// ex_div_unit: multi-cycle 32/32 restoring divider for the EX stage.
// Produces {remainder, quotient} on result_o after 32 shift-subtract steps.
// Build option: define DIV_SIGNED_EN to enable signed DIV handling; without
// it every divide is unsigned and signed_div_i is ignored.
module ex_div_unit (
  input  logic        clk,
  input  logic        rst,
  input  logic        signed_div_i,
  input  logic [31:0] opdata1_i,
  input  logic [31:0] opdata2_i,
  input  logic        start_i,
  input  logic        annul_i,
  output logic [63:0] result_o,
  output logic        ready_o
);

  typedef enum logic [1:0] {S_IDLE, S_BYZERO, S_ON, S_END} state_t;

  state_t      r_state;
  logic [5:0]  r_cnt;
  logic [64:0] r_work;
  logic [31:0] r_divisor;

  logic [64:0] w_shift;
  logic [32:0] w_diff;
  logic [64:0] w_step;
  logic [31:0] w_mag1;
  logic [31:0] w_mag2;
  logic [31:0] w_quo;
  logic [31:0] w_rem;
  logic        w_unused_msb;

  // One restoring step: shift left, trial-subtract divisor from the upper half,
  // keep the difference and shift in a 1 only if it did not go negative.
  assign w_shift      = {r_work[63:0], 1'b0};
  assign w_diff       = w_shift[64:32] - {1'b0, r_divisor};
  assign w_step       = w_diff[32] ? w_shift : {w_diff, w_shift[31:1], 1'b1};
  // The top bit of the working register is always zero after a step.
  assign w_unused_msb = r_work[64];

`ifdef DIV_SIGNED_EN
  logic r_neg_q;
  logic r_neg_r;
  logic w_neg1;
  logic w_neg2;

  assign w_neg1 = signed_div_i & opdata1_i[31];
  assign w_neg2 = signed_div_i & opdata2_i[31];
  assign w_mag1 = w_neg1 ? (32'd0 - opdata1_i) : opdata1_i;
  assign w_mag2 = w_neg2 ? (32'd0 - opdata2_i) : opdata2_i;
  // Quotient negative when signs differ; remainder follows the dividend.
  assign w_quo  = r_neg_q ? (32'd0 - r_work[31:0])  : r_work[31:0];
  assign w_rem  = r_neg_r ? (32'd0 - r_work[63:32]) : r_work[63:32];

  // Capture the fix-up signs together with the operands.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_neg_q <= 1'b0;
      r_neg_r <= 1'b0;
    end else if (r_state == S_IDLE && start_i && !annul_i) begin
      r_neg_q <= w_neg1 ^ w_neg2;
      r_neg_r <= w_neg1;
    end
  end
`else
  logic w_unused_sign;

  assign w_unused_sign = signed_div_i;
  assign w_mag1        = opdata1_i;
  assign w_mag2        = opdata2_i;
  assign w_quo         = r_work[31:0];
  assign w_rem         = r_work[63:32];
`endif

  // Divider control FSM with registered result and ready.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state   <= S_IDLE;
      r_cnt     <= 6'd0;
      r_work    <= 65'd0;
      r_divisor <= 32'd0;
      result_o  <= 64'h0;
      ready_o   <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          ready_o  <= 1'b0;
          result_o <= 64'h0;
          if (start_i && !annul_i) begin
            r_cnt     <= 6'd0;
            r_work    <= {33'd0, w_mag1};
            r_divisor <= w_mag2;
            r_state   <= (opdata2_i == 32'd0) ? S_BYZERO : S_ON;
          end
        end
        S_BYZERO: begin
          if (annul_i) begin
            r_state <= S_IDLE;
          end else begin
            r_state  <= S_END;
            result_o <= 64'h0;
            ready_o  <= 1'b1;
          end
        end
        S_ON: begin
          if (annul_i) begin
            r_state <= S_IDLE;
            r_cnt   <= 6'd0;
          end else if (r_cnt == 6'd32) begin
            r_state  <= S_END;
            result_o <= {w_rem, w_quo};
            ready_o  <= 1'b1;
          end else begin
            r_work <= w_step;
            r_cnt  <= r_cnt + 6'd1;
          end
        end
        S_END: begin
          if (annul_i || !start_i) begin
            r_state  <= S_IDLE;
            result_o <= 64'h0;
            ready_o  <= 1'b0;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_ex_div_unit.sv
// tb_ex_div_unit: directed and random divides checked against an arithmetic
// reference model of the divider.
module tb_ex_div_unit;

  logic        clk;
  logic        rst;
  logic        signed_div_i;
  logic [31:0] opdata1_i;
  logic [31:0] opdata2_i;
  logic        start_i;
  logic        annul_i;
  logic [63:0] result_o;
  logic        ready_o;

  int n_checks;
  int n_fail;

  ex_div_unit dut (
    .clk          (clk),
    .rst          (rst),
    .signed_div_i (signed_div_i),
    .opdata1_i    (opdata1_i),
    .opdata2_i    (opdata2_i),
    .start_i      (start_i),
    .annul_i      (annul_i),
    .result_o     (result_o),
    .ready_o      (ready_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference: {remainder, quotient} from plain integer division.
  function automatic logic [63:0] ref_div(input logic sgn, input logic [31:0] a,
                                          input logic [31:0] b);
    longint la, lb, q, r;
    logic [31:0] q32, r32;
    if (b == 32'd0) return 64'h0;
`ifdef DIV_SIGNED_EN
    if (sgn) begin
      la = longint'($signed(a));
      lb = longint'($signed(b));
    end else begin
      la = longint'({32'd0, a});
      lb = longint'({32'd0, b});
    end
`else
    la = longint'({32'd0, a});
    lb = longint'({32'd0, b});
`endif
    q = la / lb;
    r = la % lb;
    q32 = q[31:0];
    r32 = r[31:0];
    return {r32, q32};
  endfunction

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  // Full transaction: start, wait for ready, check latency and result,
  // check hold in END with changed inputs, then release start.
  task automatic run_div(input logic sgn, input logic [31:0] a, input logic [31:0] b,
                         input logic [63:0] exp, input string tag);
    int n;
    int lat_exp;
    lat_exp = (b == 32'd0) ? 2 : 34;
    signed_div_i = sgn;
    opdata1_i    = a;
    opdata2_i    = b;
    start_i      = 1'b1;
    n = 0;
    do begin
      tick();
      n++;
      opdata1_i    = $urandom;
      opdata2_i    = $urandom;
      signed_div_i = ~sgn;
    end while (!ready_o && n < 100);
    check({tag, " latency"}, 64'(n), 64'(lat_exp));
    check({tag, " result"}, result_o, exp);
    tick();
    check({tag, " hold ready"}, 64'(ready_o), 64'd1);
    check({tag, " hold result"}, result_o, exp);
    start_i = 1'b0;
    tick();
    check({tag, " release ready"}, 64'(ready_o), 64'd0);
    check({tag, " release result"}, result_o, 64'h0);
  endtask

  initial begin
    logic        s;
    logic [31:0] a, b;
    int          n;
    n_checks     = 0;
    n_fail       = 0;
    rst          = 1'b1;
    signed_div_i = 1'b0;
    opdata1_i    = 32'd0;
    opdata2_i    = 32'd0;
    start_i      = 1'b1;
    annul_i      = 1'b1;
    @(negedge clk);
    tick();
    check("reset ready", 64'(ready_o), 64'd0);
    check("reset result", result_o, 64'h0);
    rst     = 1'b0;
    start_i = 1'b0;
    annul_i = 1'b0;
    tick();

    run_div(1'b0, 32'd100, 32'd7, 64'h00000002_0000000E, "divu_100_7");
`ifdef DIV_SIGNED_EN
    run_div(1'b1, 32'hFFFFFFF9, 32'd2, 64'hFFFFFFFF_FFFFFFFD, "div_m7_2");
    run_div(1'b1, 32'h80000000, 32'hFFFFFFFF, 64'h00000000_80000000, "div_min_m1");
    run_div(1'b1, 32'd7, 32'hFFFFFFFE, 64'h00000001_FFFFFFFD, "div_7_m2");
`else
    run_div(1'b1, 32'hFFFFFFF9, 32'd2, 64'h00000001_7FFFFFFC, "div_unsigned_build");
    run_div(1'b1, 32'h80000000, 32'hFFFFFFFF, 64'h80000000_00000000, "divu_min_max");
`endif
    run_div(1'b0, 32'h1234, 32'd0, 64'h0, "div_by_zero");
    run_div(1'b0, 32'hFFFFFFFF, 32'd1, 64'h00000000_FFFFFFFF, "divu_max_1");
    run_div(1'b0, 32'd5, 32'hFFFFFFFF, 64'h00000005_00000000, "divu_small_big");

    // Annul and start together in IDLE: nothing starts.
    start_i   = 1'b1;
    annul_i   = 1'b1;
    opdata1_i = 32'd100;
    opdata2_i = 32'd0;
    repeat (3) tick();
    check("annul_idle ready", 64'(ready_o), 64'd0);
    start_i = 1'b0;
    annul_i = 1'b0;
    tick();

    // Annul mid-operation, sampled at edge 10.
    signed_div_i = 1'b0;
    opdata1_i    = 32'd100;
    opdata2_i    = 32'd7;
    start_i      = 1'b1;
    repeat (9) tick();
    annul_i = 1'b1;
    tick();
    check("annul_on ready", 64'(ready_o), 64'd0);
    check("annul_on result", result_o, 64'h0);
    annul_i = 1'b0;
    start_i = 1'b0;
    repeat (40) tick();
    check("annul_on stays idle", 64'(ready_o), 64'd0);
    run_div(1'b0, 32'd100, 32'd7, 64'h00000002_0000000E, "after_annul");

    // Annul in END while start is still high.
    opdata1_i = 32'd50;
    opdata2_i = 32'd5;
    start_i   = 1'b1;
    n = 0;
    do begin
      tick();
      n++;
    end while (!ready_o && n < 100);
    check("end result", result_o, 64'h00000000_0000000A);
    annul_i = 1'b1;
    tick();
    check("annul_end ready", 64'(ready_o), 64'd0);
    check("annul_end result", result_o, 64'h0);
    annul_i = 1'b0;
    start_i = 1'b0;
    tick();

    // Reset mid-operation leaves nothing visible.
    opdata1_i = 32'd1000;
    opdata2_i = 32'd3;
    start_i   = 1'b1;
    repeat (20) tick();
    rst = 1'b1;
    tick();
    rst     = 1'b0;
    start_i = 1'b0;
    check("midrst ready", 64'(ready_o), 64'd0);
    check("midrst result", result_o, 64'h0);
    repeat (20) tick();
    check("midrst stays idle", 64'(ready_o), 64'd0);

    // Random operands against the reference model.
    for (int i = 0; i < 12; i++) begin
      s = 1'($urandom_range(0, 1));
      a = $urandom;
      case ($urandom_range(0, 3))
        0:       b = 32'd0;
        1:       b = $urandom_range(1, 255);
        2:       b = 32'hFFFFFF00 | $urandom_range(0, 255);
        default: b = $urandom;
      endcase
      run_div(s, a, b, ref_div(s, a, b), $sformatf("rand%0d", i));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
